// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demux with valid/ready handshake.
// It has one output slot and one transfer counter per channel.
module demux_1to2_reg #(
  parameter int size  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);

  logic free0;
  logic free1;
  logic accept;
  logic load0;
  logic load1;
  logic drain0;
  logic drain1;

  // A slot is free when it is empty or is being drained this cycle.
  assign free0  = !valid0_o || ready0_i;
  assign free1  = !valid1_o || ready1_i;
  assign ready_o = select_i ? free1 : free0;

  assign accept = valid_i && ready_o;
  assign load0  = accept && !select_i;
  assign load1  = accept && select_i;
  assign drain0 = valid0_o && ready0_i;
  assign drain1 = valid1_o && ready1_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data0_o  <= '0;
      valid0_o <= 1'b0;
      cnt0_o   <= '0;
    end else begin
      if (load0) begin
        data0_o  <= data_i;
        valid0_o <= 1'b1;
      end else if (drain0) begin
        valid0_o <= 1'b0;
      end
      if (drain0) begin
        cnt0_o <= cnt0_o + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data1_o  <= '0;
      valid1_o <= 1'b0;
      cnt1_o   <= '0;
    end else begin
      if (load1) begin
        data1_o  <= data_i;
        valid1_o <= 1'b1;
      end else if (drain1) begin
        valid1_o <= 1'b0;
      end
      if (drain1) begin
        cnt1_o <= cnt1_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Scoreboard bench for demux_1to2_reg.
// A second instance with 4-bit counters exercises counter wrap.
module tb_demux_1to2_reg;

  logic       clk = 1'b0;
  logic       t_rst;
  logic [7:0] t_d;
  logic       t_sel;
  logic       t_v;
  logic       t_r0;
  logic       t_r1;

  logic       ready_o;
  logic [7:0] data0_o;
  logic       valid0_o;
  logic [7:0] data1_o;
  logic       valid1_o;
  logic [7:0] cnt0_o;
  logic [7:0] cnt1_o;

  logic       w_ready;
  logic [7:0] w_data0;
  logic       w_valid0;
  logic [7:0] w_data1;
  logic       w_valid1;
  logic [3:0] w_cnt0;
  logic [3:0] w_cnt1;

  always #5 clk = ~clk;

  demux_1to2_reg #(.size(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(t_rst), .data_i(t_d),
    .select_i(t_sel), .valid_i(t_v), .ready_o(ready_o),
    .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(t_r0),
    .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(t_r1),
    .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
  );

  demux_1to2_reg #(.size(8), .CNT_W(4)) dut_w (
    .clk_i(clk), .rst_i(t_rst), .data_i(t_d),
    .select_i(t_sel), .valid_i(t_v), .ready_o(w_ready),
    .data0_o(w_data0), .valid0_o(w_valid0), .ready0_i(t_r0),
    .data1_o(w_data1), .valid1_o(w_valid1), .ready1_i(t_r1),
    .cnt0_o(w_cnt0), .cnt1_o(w_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  logic mv0 = 1'b0;
  logic mv1 = 1'b0;
  int   mc0 = 0;
  int   mc1 = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return t_sel ? (!mv1 || t_r1) : (!mv0 || t_r0);
  endfunction

  // Reference model of slot occupancy and counters.
  always @(posedge clk) begin
    if (t_rst) begin
      mv0 <= 1'b0;
      mv1 <= 1'b0;
      mc0 <= 0;
      mc1 <= 0;
      q0.delete();
      q1.delete();
    end else begin
      if (t_v && m_ready() && !t_sel) mv0 <= 1'b1;
      else if (mv0 && t_r0)           mv0 <= 1'b0;
      if (t_v && m_ready() && t_sel)  mv1 <= 1'b1;
      else if (mv1 && t_r1)           mv1 <= 1'b0;
      if (mv0 && t_r0) mc0 <= mc0 + 1;
      if (mv1 && t_r1) mc1 <= mc1 + 1;
    end
  end

  // Monitor: compares everything mid-cycle and pops on handshakes.
  always @(negedge clk) begin
    if (armed) begin
      check("ready", 32'(ready_o), 32'(m_ready()));
      check("valid0", 32'(valid0_o), 32'(mv0));
      check("valid1", 32'(valid1_o), 32'(mv1));
      check("cnt0", 32'(cnt0_o), 32'(mc0 & 255));
      check("cnt1", 32'(cnt1_o), 32'(mc1 & 255));
      check("w_cnt0", 32'(w_cnt0), 32'(mc0 & 15));
      check("w_cnt1", 32'(w_cnt1), 32'(mc1 & 15));
      check("w_valid1", 32'(w_valid1), 32'(mv1));
      if (valid0_o === 1'b1) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ch0_spurious: got %0h expected none", data0_o);
        end else begin
          check("data0", 32'(data0_o), 32'(q0[0]));
          if (t_r0) void'(q0.pop_front());
        end
      end
      if (valid1_o === 1'b1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ch1_spurious: got %0h expected none", data1_o);
        end else begin
          check("data1", 32'(data1_o), 32'(q1[0]));
          if (t_r1) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic step(input logic rst, input logic v,
                      input logic sel, input logic [7:0] d,
                      input logic r0, input logic r1);
    @(posedge clk);
    #1;
    t_rst = rst;
    t_v   = v;
    t_sel = sel;
    t_d   = d;
    t_r0  = r0;
    t_r1  = r1;
    if (!rst && v && m_ready()) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 1, 1);
  endtask

  initial begin
    t_rst = 1'b1;
    t_v   = 1'b0;
    t_sel = 1'b0;
    t_d   = 8'h00;
    t_r0  = 1'b1;
    t_r1  = 1'b1;

    step(1, 0, 0, 8'h00, 1, 1);
    step(1, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    armed = 1'b1;
    check("rst_valid0", 32'(valid0_o), 0);
    check("rst_valid1", 32'(valid1_o), 0);
    check("rst_data0", 32'(data0_o), 0);
    check("rst_data1", 32'(data1_o), 0);
    check("rst_cnt0", 32'(cnt0_o), 0);
    check("rst_cnt1", 32'(cnt1_o), 0);
    check("rst_ready", 32'(ready_o), 1);

    step(0, 1, 0, 8'hA5, 1, 1);
    step(0, 1, 1, 8'h3C, 1, 1);
    check("rt_data0", 32'(data0_o), 32'h00A5);
    check("rt_valid0", 32'(valid0_o), 1);
    idle(1);
    check("rt_data1", 32'(data1_o), 32'h003C);
    check("rt_valid1", 32'(valid1_o), 1);
    idle(2);
    check("rt_cnt0", 32'(cnt0_o), 1);
    check("rt_cnt1", 32'(cnt1_o), 1);

    step(1, 0, 0, 8'h00, 1, 1);
    step(0, 1, 0, 8'h11, 0, 1);
    step(0, 1, 0, 8'h22, 0, 1);
    check("st_data0", 32'(data0_o), 32'h0011);
    check("st_ready_blk", 32'(ready_o), 0);
    step(0, 1, 1, 8'h33, 0, 1);
    check("st_ready_ch1", 32'(ready_o), 1);
    step(0, 1, 0, 8'h22, 1, 1);
    check("st_data1", 32'(data1_o), 32'h0033);
    check("st_hold0", 32'(data0_o), 32'h0011);
    idle(1);
    check("st_data0_new", 32'(data0_o), 32'h0022);
    idle(2);
    check("st_cnt0", 32'(cnt0_o), 2);
    check("st_cnt1", 32'(cnt1_o), 1);

    step(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h40 + 8'(i), 1, 1);
      check("tp_ready", 32'(ready_o), 1);
    end
    idle(2);
    check("tp_cnt0", 32'(cnt0_o), 16);

    step(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 8'(i * 3), 1, 1);
    idle(2);
    check("wr_w_cnt1", 32'(w_cnt1), 1);
    check("wr_cnt1", 32'(cnt1_o), 17);
    check("wr_w_cnt0", 32'(w_cnt0), 0);

    step(0, 1, 0, 8'hAA, 0, 0);
    step(0, 1, 1, 8'hBB, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    check("mr_full0", 32'(valid0_o), 1);
    check("mr_full1", 32'(valid1_o), 1);
    step(0, 0, 0, 8'h00, 1, 1);
    check("mr_valid0", 32'(valid0_o), 0);
    check("mr_valid1", 32'(valid1_o), 0);
    check("mr_cnt0", 32'(cnt0_o), 0);
    check("mr_cnt1", 32'(cnt1_o), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
